// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: default operand width, divider state encoding
// and the iteration-counter sizing helper.
package arith_pkg;

  localparam int WIDTH_DEF = 11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } div_state_e;

  // Counter must index 0 .. 2*w-1.
  function automatic int cnt_width(input int w);
    return (2 * w > 1) ? $clog2(2 * w) : 1;
  endfunction

endpackage

// File: rtl/serial_div_step.sv
// One combinational restoring-division step: shift the next dividend bit into
// the partial remainder and subtract the divisor when it fits.
module serial_div_step
  import arith_pkg::*;
#(
  parameter int width = WIDTH_DEF
) (
  input  logic [width:0]   rem_i,
  input  logic             dvd_bit_i,
  input  logic [width-1:0] dsr_i,
  output logic [width:0]   rem_o,
  output logic             q_bit_o
);

  logic [width+1:0] shifted;
  logic [width+1:0] dsr_ext;

  assign shifted = {rem_i, dvd_bit_i};
  assign dsr_ext = (width + 2)'(dsr_i);

  always_comb begin
    q_bit_o = (shifted >= dsr_ext);
    rem_o   = q_bit_o ? (width + 1)'(shifted - dsr_ext) : (width + 1)'(shifted);
  end

endmodule

// File: rtl/signed_serial_divider_11.sv
// Signed 2W/W serial divider: magnitude restoring loop over 2W cycles, then a
// single fix-up cycle applying signs, saturation and divide-by-zero handling.
module signed_serial_divider_11
  import arith_pkg::*;
#(
  parameter int width = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [2*width-1:0] A,
  input  logic [width-1:0]   B,
  output logic               valid,
  output logic [width-1:0]   Q,
  output logic [width-1:0]   R,
  output logic               dbz,
  output logic               ovf
);

  localparam int DW    = 2 * width;
  localparam int CNT_W = cnt_width(width);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DW - 1);
  localparam logic [DW-1:0]    POS_LIM   = DW'((1 << (width - 1)) - 1);
  localparam logic [DW-1:0]    NEG_LIM   = DW'(1 << (width - 1));
  localparam logic [width-1:0] Q_SAT_POS = {1'b0, {(width - 1){1'b1}}};
  localparam logic [width-1:0] Q_SAT_NEG = {1'b1, {(width - 1){1'b0}}};

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DW-1:0]    dvd_q, dvd_d;
  logic [width-1:0] bmag_q, bmag_d;
  logic [width:0]   rem_q, rem_d;
  logic             sq_q, sq_d;
  logic             sr_q, sr_d;
  logic             valid_q, valid_d;
  logic [width-1:0] q_q, q_d;
  logic [width-1:0] r_q, r_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;

  logic [DW-1:0]    a_mag;
  logic [width-1:0] b_mag;
  logic [width:0]   step_rem;
  logic             step_qbit;
  logic [width-1:0] q_mag_lo;
  logic [width-1:0] rem_lo;

  // The most negative dividend negates to itself, which is its correct unsigned magnitude.
  assign a_mag    = A[DW-1] ? -A : A;
  assign b_mag    = B[width-1] ? -B : B;
  assign q_mag_lo = dvd_q[width-1:0];
  assign rem_lo   = rem_q[width-1:0];

  serial_div_step #(.width(width)) u_step (
    .rem_i     (rem_q),
    .dvd_bit_i (dvd_q[DW-1]),
    .dsr_i     (bmag_q),
    .rem_o     (step_rem),
    .q_bit_o   (step_qbit)
  );

  always_comb begin
    // NOTE: every _d takes its held value first, so no path through the case infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    bmag_d  = bmag_q;
    rem_d   = rem_q;
    sq_d    = sq_q;
    sr_d    = sr_q;
    valid_d = valid_q;
    q_d     = q_q;
    r_d     = r_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (en) begin
          state_d = ST_CALC;
          cnt_d   = '0;
          dvd_d   = a_mag;
          bmag_d  = b_mag;
          rem_d   = '0;
          sq_d    = A[DW-1] ^ B[width-1];
          sr_d    = A[DW-1];
          valid_d = 1'b0;
        end
      end
      ST_CALC: begin
        // Quotient bits shift in from the bottom as dividend bits leave the top.
        rem_d = step_rem;
        dvd_d = {dvd_q[DW-2:0], step_qbit};
        if (cnt_q == LAST_ITER) begin
          state_d = ST_FIX;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_FIX: begin
        state_d = ST_DONE;
        valid_d = 1'b1;
        if (bmag_q == '0) begin
          dbz_d = 1'b1;
          ovf_d = 1'b0;
          q_d   = '0;
          r_d   = '0;
        end else begin
          dbz_d = 1'b0;
          r_d   = sr_q ? -rem_lo : rem_lo;
          if (!sq_q && (dvd_q > POS_LIM)) begin
            ovf_d = 1'b1;
            q_d   = Q_SAT_POS;
          end else if (sq_q && (dvd_q > NEG_LIM)) begin
            ovf_d = 1'b1;
            q_d   = Q_SAT_NEG;
          end else begin
            ovf_d = 1'b0;
            q_d   = sq_q ? -q_mag_lo : q_mag_lo;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      bmag_q  <= '0;
      rem_q   <= '0;
      sq_q    <= 1'b0;
      sr_q    <= 1'b0;
      valid_q <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      bmag_q  <= bmag_d;
      rem_q   <= rem_d;
      sq_q    <= sq_d;
      sr_q    <= sr_d;
      valid_q <= valid_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign valid = valid_q;
  assign Q     = q_q;
  assign R     = r_q;
  assign dbz   = dbz_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_signed_serial_divider_11.sv
// Scoreboard bench for signed_serial_divider_11: expected results are queued at
// issue time and compared when valid rises, together with the fixed latency.
module tb_signed_serial_divider_11;

  localparam int W   = 11;
  localparam int LAT = 2 * W + 1;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    logic         ovf;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           en = 1'b0;
  logic [2*W-1:0] A = '0;
  logic [W-1:0]   B = '0;
  logic           valid;
  logic [W-1:0]   Q;
  logic [W-1:0]   R;
  logic           dbz;
  logic           ovf;

  exp_t         sb[$];
  logic [W-1:0] last_q;
  int           n_cmp = 0;
  int           n_bad = 0;

  signed_serial_divider_11 #(.width(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .A     (A),
    .B     (B),
    .valid (valid),
    .Q     (Q),
    .R     (R),
    .dbz   (dbz),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input int a, input int b);
    exp_t e;
    int   q;
    int   r;
    e.dbz = 1'b0;
    e.ovf = 1'b0;
    if (b == 0) begin
      e.dbz = 1'b1;
      e.q   = '0;
      e.r   = '0;
      return e;
    end
    q = a / b;
    r = a % b;
    if (q > 1023) begin
      e.ovf = 1'b1;
      q     = 1023;
    end else if (q < -1024) begin
      e.ovf = 1'b1;
      q     = -1024;
    end
    e.q = q[W-1:0];
    e.r = r[W-1:0];
    return e;
  endfunction

  task automatic push_exp(input int q, input int r, input logic d, input logic o);
    exp_t e;
    e.q   = q[W-1:0];
    e.r   = r[W-1:0];
    e.dbz = d;
    e.ovf = o;
    sb.push_back(e);
  endtask

  // Counts edges after the accepting edge until valid, then pops and compares.
  task automatic wait_result(input string tag, input int n0);
    exp_t e;
    int   n;
    n = n0;
    while (n < LAT + 10) begin
      @(posedge clk);
      #1;
      n++;
      if (valid) break;
    end
    n_cmp++;
    if (!valid || n != LAT) begin
      n_bad++;
      $display("FAIL %s latency: got %0d cycles (valid=%b), want %0d", tag, n, valid, LAT);
    end
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s scoreboard: got empty queue, want one entry", tag);
      return;
    end
    e = sb.pop_front();
    last_q = e.q;
    n_cmp++;
    if ({Q, R, dbz, ovf} !== {e.q, e.r, e.dbz, e.ovf}) begin
      n_bad++;
      $display("FAIL %s result: got Q=%0d R=%0d dbz=%b ovf=%b, want Q=%0d R=%0d dbz=%b ovf=%b",
               tag, $signed(Q), $signed(R), dbz, ovf, $signed(e.q), $signed(e.r), e.dbz, e.ovf);
    end
  endtask

  task automatic issue(input int a, input int b);
    @(negedge clk);
    A  = a[2*W-1:0];
    B  = b[W-1:0];
    en = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b0;
  endtask

  task automatic do_op(input int a, input int b, input string tag);
    issue(a, b);
    wait_result(tag, 0);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({valid, Q, R, dbz, ovf} !== '0) begin
      n_bad++;
      $display("FAIL reset_state: got valid=%b Q=%h R=%h dbz=%b ovf=%b, want all 0",
               valid, Q, R, dbz, ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    push_exp(17, 0, 1'b0, 1'b0);
    do_op(391, 23, "basic_391_23");
  endtask

  task automatic test_signs;
    push_exp(-14, -2, 1'b0, 1'b0);
    do_op(-100, 7, "neg_dividend");
    push_exp(-14, 2, 1'b0, 1'b0);
    do_op(100, -7, "neg_divisor");
    push_exp(14, -2, 1'b0, 1'b0);
    do_op(-100, -7, "both_neg");
  endtask

  task automatic test_dbz;
    push_exp(0, 0, 1'b1, 1'b0);
    do_op(5, 0, "div_by_zero");
  endtask

  task automatic test_ovf;
    push_exp(1023, 0, 1'b0, 1'b1);
    do_op(-1048576, -1, "ovf_min_by_m1");
    push_exp(-1024, 0, 1'b0, 1'b0);
    do_op(-1024, 1, "exact_neg_bound");
    push_exp(-1024, 0, 1'b0, 1'b1);
    do_op(2000, -1, "ovf_neg_sat");
  endtask

  task automatic test_done_restart;
    logic [W-1:0] held_q;
    held_q = last_q;
    n_cmp++;
    if (valid !== 1'b1) begin
      n_bad++;
      $display("FAIL done_precondition: got valid=%b, want 1", valid);
    end
    push_exp(100, 0, 1'b0, 1'b0);
    issue(1000, 10);
    n_cmp++;
    if (valid !== 1'b0 || Q !== held_q) begin
      n_bad++;
      $display("FAIL done_accept: got valid=%b Q=%h, want valid=0 Q=%h", valid, Q, held_q);
    end
    wait_result("done_restart", 0);
  endtask

  task automatic test_en_held;
    push_exp(-42, -6, 1'b0, 1'b0);
    @(negedge clk);
    A  = 22'(-300);
    B  = 11'd7;
    en = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 15; i++) begin
      A = 22'(12345 + i);
      B = 11'd3;
      @(posedge clk);
      #1;
    end
    en = 1'b0;
    wait_result("en_held", 15);
  endtask

  task automatic test_reset_mid;
    issue(777, 5);
    repeat (8) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({valid, Q, R, dbz, ovf} !== '0) begin
      n_bad++;
      $display("FAIL reset_mid_calc: got valid=%b Q=%h R=%h dbz=%b ovf=%b, want all 0",
               valid, Q, R, dbz, ovf);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    push_exp(155, 2, 1'b0, 1'b0);
    do_op(777, 5, "after_reset");
  endtask

  task automatic test_random_exact;
    int a;
    int b;
    for (int i = 0; i < 50; i++) begin
      a = int'($urandom_range(0, 2047)) - 1024;
      do b = int'($urandom_range(0, 2047)) - 1024; while (b == 0);
      push_exp(a, 0, 1'b0, 1'b0);
      do_op(a * b, b, "rand_exact");
    end
  endtask

  task automatic test_random;
    int a;
    int b;
    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0) a = int'($urandom_range(0, (1 << 22) - 1)) - (1 << 21);
      else            a = int'($urandom_range(0, 8191)) - 4096;
      b = int'($urandom_range(0, 2047)) - 1024;
      sb.push_back(model(a, b));
      do_op(a, b, "rand_general");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signs();
    test_dbz();
    test_ovf();
    test_done_restart();
    test_en_held();
    test_reset_mid();
    test_random_exact();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
